// File: rtl/hex_stopwatch_counter.sv
// Four-digit BCD stopwatch (SS.hh, 00.00-59.99) driven by start/stop and clear buttons.
// Each digit feeds one 7-segment hex decoder; digits never leave the BCD range.
module hex_stopwatch_counter #(
    parameter int unsigned TICK_DIV = 500000,
    parameter int unsigned PS_W     = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startStop,
    input  logic       clear,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       running,
    output logic       overflow
);

    localparam int unsigned DIGIT_W = 4;
    localparam logic [PS_W-1:0]    PS_LAST   = PS_W'(TICK_DIV - 1);
    localparam logic [DIGIT_W-1:0] DEC_MAX   = DIGIT_W'(9);
    localparam logic [DIGIT_W-1:0] TENS_MAX  = DIGIT_W'(5);
    localparam logic [DIGIT_W-1:0] DIGIT_ONE = DIGIT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t state;

    logic              ss_sync1;
    logic              ss_sync2;
    logic              ss_prev;
    logic              clr_sync1;
    logic              clr_sync2;
    logic              clr_prev;
    logic              ss_edge;
    logic              clr_edge;
    logic [PS_W-1:0]   prescaler;
    logic              tick;
    logic [DIGIT_W-1:0] next_d0;
    logic [DIGIT_W-1:0] next_d1;
    logic [DIGIT_W-1:0] next_d2;
    logic [DIGIT_W-1:0] next_d3;
    logic              wrap;

    // Two-flop synchronizers plus a previous-value flop for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_sync1  <= 1'b0;
            ss_sync2  <= 1'b0;
            ss_prev   <= 1'b0;
            clr_sync1 <= 1'b0;
            clr_sync2 <= 1'b0;
            clr_prev  <= 1'b0;
        end else begin
            ss_sync1  <= startStop;
            ss_sync2  <= ss_sync1;
            ss_prev   <= ss_sync2;
            clr_sync1 <= clear;
            clr_sync2 <= clr_sync1;
            clr_prev  <= clr_sync2;
        end
    end

    assign ss_edge  = ss_sync2 & ~ss_prev;
    assign clr_edge = clr_sync2 & ~clr_prev;
    assign tick     = (state == RUN) && (prescaler == PS_LAST);

    // Incremented digit set with the carry chain resolved in one cycle
    always_comb begin
        next_d0 = digit0;
        next_d1 = digit1;
        next_d2 = digit2;
        next_d3 = digit3;
        wrap    = 1'b0;
        if (digit0 == DEC_MAX) begin
            next_d0 = '0;
            if (digit1 == DEC_MAX) begin
                next_d1 = '0;
                if (digit2 == DEC_MAX) begin
                    next_d2 = '0;
                    if (digit3 == TENS_MAX) begin
                        next_d3 = '0;
                        wrap    = 1'b1;
                    end else begin
                        next_d3 = digit3 + DIGIT_ONE;
                    end
                end else begin
                    next_d2 = digit2 + DIGIT_ONE;
                end
            end else begin
                next_d1 = digit1 + DIGIT_ONE;
            end
        end else begin
            next_d0 = digit0 + DIGIT_ONE;
        end
    end

    // Control FSM with prescaler and digit registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            running   <= 1'b0;
            overflow  <= 1'b0;
            prescaler <= '0;
            digit0    <= '0;
            digit1    <= '0;
            digit2    <= '0;
            digit3    <= '0;
        end else begin
            case (state)
                IDLE, PAUSED: begin
                    // clear wins over a simultaneous start/stop outside RUN
                    if (clr_edge) begin
                        state     <= IDLE;
                        running   <= 1'b0;
                        overflow  <= 1'b0;
                        prescaler <= '0;
                        digit0    <= '0;
                        digit1    <= '0;
                        digit2    <= '0;
                        digit3    <= '0;
                    end else if (ss_edge) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    // A tick in the same cycle as a pause edge still lands
                    if (tick) begin
                        prescaler <= '0;
                        digit0    <= next_d0;
                        digit1    <= next_d1;
                        digit2    <= next_d2;
                        digit3    <= next_d3;
                        if (wrap) begin
                            overflow <= 1'b1;
                        end
                    end else begin
                        prescaler <= prescaler + PS_W'(1);
                    end
                    if (ss_edge) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_stopwatch_counter.sv
// Bench for hex_stopwatch_counter: directed tick-count table, corner sequences,
// and random button activity compared against an elapsed-hundredths reference model.
module tb_hex_stopwatch_counter;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned PS_W     = 3;
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       startStop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic       running;
    logic       overflow;
    logic [15:0] bcd;

    hex_stopwatch_counter #(
        .TICK_DIV(TICK_DIV),
        .PS_W    (PS_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .startStop(startStop),
        .clear    (clear),
        .digit0   (digit0),
        .digit1   (digit1),
        .digit2   (digit2),
        .digit3   (digit3),
        .running  (running),
        .overflow (overflow)
    );

    assign bcd = {digit3, digit2, digit1, digit0};

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: elapsed time in hundredths plus input level history per edge
    int m_mode;
    int m_count;
    int m_phase;
    bit m_ovf;
    bit hs[4];
    bit hc[4];

    function automatic void model_reset();
        m_mode  = M_IDLE;
        m_count = 0;
        m_phase = 0;
        m_ovf   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hs[i] = 1'b0;
            hc[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge(input bit ss, input bit clr);
        bit e_ss;
        bit e_clr;
        for (int i = 3; i > 0; i--) begin
            hs[i] = hs[i-1];
            hc[i] = hc[i-1];
        end
        hs[0] = ss;
        hc[0] = clr;
        // a level seen two edges ago that was low three edges ago acts now
        e_ss  = hs[2] && !hs[3];
        e_clr = hc[2] && !hc[3];
        if (m_mode == M_RUN) begin
            if (m_phase == int'(TICK_DIV) - 1) begin
                m_phase = 0;
                m_count = m_count + 1;
                if (m_count == 6000) begin
                    m_count = 0;
                    m_ovf   = 1'b1;
                end
            end else begin
                m_phase = m_phase + 1;
            end
            if (e_ss) m_mode = M_PAUSED;
        end else if (e_clr) begin
            m_mode  = M_IDLE;
            m_count = 0;
            m_phase = 0;
            m_ovf   = 1'b0;
        end else if (e_ss) begin
            m_mode = M_RUN;
        end
    endfunction

    function automatic logic [15:0] model_bcd();
        return {4'(m_count / 1000), 4'((m_count / 100) % 10),
                4'((m_count / 10) % 10), 4'(m_count % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        check(name, 32'({bcd, running, overflow}),
              32'({model_bcd(), (m_mode == M_RUN), m_ovf}));
    endtask

    task automatic step(input bit ss, input bit clr);
        startStop = ss;
        clear     = clr;
        @(posedge clk);
        model_edge(ss, clr);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        startStop = 1'b0;
        clear     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic start_run();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("running_before_3rd_edge", 32'(running), 32'd0);
        step(1'b0, 1'b0);
        check("running_on_3rd_edge", 32'(running), 32'd1);
    endtask

    typedef struct {
        int unsigned ticks;
        bit          clr_pulse;
        logic [15:0] exp_bcd;
        bit          exp_ovf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int unsigned elapsed;
        bit ss_l;
        bit clr_l;

        vecs[0] = '{ticks: 1,    clr_pulse: 1'b0, exp_bcd: 16'h0001, exp_ovf: 1'b0};
        vecs[1] = '{ticks: 9,    clr_pulse: 1'b1, exp_bcd: 16'h0009, exp_ovf: 1'b0};
        vecs[2] = '{ticks: 10,   clr_pulse: 1'b0, exp_bcd: 16'h0010, exp_ovf: 1'b0};
        vecs[3] = '{ticks: 999,  clr_pulse: 1'b0, exp_bcd: 16'h0999, exp_ovf: 1'b0};
        vecs[4] = '{ticks: 1000, clr_pulse: 1'b0, exp_bcd: 16'h1000, exp_ovf: 1'b0};
        vecs[5] = '{ticks: 5999, clr_pulse: 1'b1, exp_bcd: 16'h5999, exp_ovf: 1'b0};
        vecs[6] = '{ticks: 6000, clr_pulse: 1'b0, exp_bcd: 16'h0000, exp_ovf: 1'b1};
        vecs[7] = '{ticks: 6010, clr_pulse: 1'b0, exp_bcd: 16'h0010, exp_ovf: 1'b1};

        // Reset held mid-run at 12.34
        do_reset();
        check("reset_outputs", 32'({bcd, running, overflow}), 32'd0);
        start_run();
        repeat (1234 * TICK_DIV) step(1'b0, 1'b0);
        check("reach_12_34", 32'(bcd), 32'h1234);
        reset = 1'b1;
        #2;
        check("async_reset_immediate", 32'({bcd, running, overflow}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check("after_reset_release", 32'({bcd, running, overflow}), 32'd0);
        repeat (100) step(1'b0, 1'b0);
        check("idle_100_cycles", 32'({bcd, running, overflow}), 32'd0);

        // Table: cumulative tick targets from a single run, with clear pulses ignored in RUN
        do_reset();
        start_run();
        elapsed = 0;
        for (int i = 0; i < 8; i++) begin
            for (int unsigned c = elapsed; c < vecs[i].ticks * TICK_DIV; c++) begin
                step(1'b0, vecs[i].clr_pulse && (c == elapsed));
            end
            elapsed = vecs[i].ticks * TICK_DIV;
            check($sformatf("vec%0d_digits", i), 32'(bcd), 32'(vecs[i].exp_bcd));
            check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_running", i), 32'(running), 32'd1);
            check_model($sformatf("vec%0d_model", i));
        end

        // Pause after overflow, then clear drops overflow and digits
        step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        check("pause_after_wrap", 32'({bcd, running, overflow}), 32'({16'h0010, 1'b0, 1'b1}));
        step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);
        check("clear_from_paused", 32'({bcd, running, overflow}), 32'd0);
        // IDLE with both edges together: clear wins, stays idle
        step(1'b1, 1'b1);
        repeat (6) step(1'b0, 1'b0);
        check("idle_both_edges", 32'({bcd, running, overflow}), 32'd0);

        // Pause with a partial hundredth, hold, and resume
        do_reset();
        start_run();
        repeat (19) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        check("paused_at_00_05", 32'({bcd, running}), 32'({16'h0005, 1'b0}));
        repeat (50) step(1'b0, 1'b0);
        check("hold_00_05", 32'({bcd, running}), 32'({16'h0005, 1'b0}));
        check_model("hold_model");
        step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        check("resume_running", 32'({bcd, running}), 32'({16'h0005, 1'b1}));
        step(1'b0, 1'b0);
        check("resume_plus1", 32'(digit0), 32'd5);
        step(1'b0, 1'b0);
        check("resume_plus2", 32'(digit0), 32'd6);

        // Both edges in RUN: pause taken, digits kept
        step(1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b0);
        check("run_both_edges", 32'({bcd, running}), 32'({16'h0006, 1'b0}));
        // Both edges in PAUSED: clear taken
        step(1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b0);
        check("paused_both_edges", 32'({bcd, running, overflow}), 32'd0);
        check_model("paused_both_model");

        // Random button activity against the model
        do_reset();
        ss_l  = 1'b0;
        clr_l = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 11) == 0) ss_l = ~ss_l;
            if ($urandom_range(0, 39) == 0) clr_l = ~clr_l;
            step(ss_l, clr_l);
            check_model("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
